reindeer_uart_tx_sched: RTL
===========================

Name: reindeer_uart_tx_sched

Overview:
Sequences the UART transmitter and shares it between two requesters: core memory-mapped stores to the UART TX register, and the on-chip debugger byte channel. Core bytes are buffered in a small FIFO so firmware can issue back-to-back stores without polling. The block sits between the memory-mapped register file's start_TX/tx_data outputs and the UART TX serializer. It paces every byte on tx_active.

Parameters:
FIFO_AW, 2, log2 of core FIFO depth (depth = 4)
START_TIMEOUT, 16, cycles to wait for tx_active rise after a start pulse

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sync_reset  input  1  synchronous reset; same effect as reset_n
core_start_TX  input  1  one-cycle push strobe from core store
core_tx_data  input  8  byte accompanying core_start_TX
core_fifo_full  output  1  core FIFO holds 2^FIFO_AW bytes
core_fifo_count  output  FIFO_AW+1  bytes currently buffered
dbg_req  input  1  debugger byte pending; held until dbg_ack
dbg_data  input  8  debugger byte, stable while dbg_req high
dbg_ack  output  1  one-cycle pulse: debugger byte accepted for transmit
uart_start_TX  output  1  one-cycle start pulse to the UART serializer
uart_tx_data  output  8  byte to the serializer, held from start until done
uart_tx_active  input  1  serializer busy
busy  output  1  high whenever state != IDLE or FIFO non-empty
overflow_err  output  1  sticky: push while FIFO full
timeout_err  output  1  sticky: tx_active never rose

Behaviour:
- Reset (reset_n low or sync_reset high): state IDLE, FIFO empty, all outputs 0, uart_tx_data 8'h00.
- FIFO: push on core_start_TX when not full. Push while full drops the byte and sets overflow_err; count is unchanged.
- Simultaneous push and pop are both performed. Count stays the same. A full FIFO accepts the push if a pop happens in the same cycle.
- Pointers wrap modulo 2^FIFO_AW. core_fifo_count is in the range 0..2^FIFO_AW.
- Byte flow: first-in first-out. A byte pushed into an empty FIFO is eligible in the next cycle, not the same cycle.
- FSM states: IDLE, START, WAIT_ACT, WAIT_DONE.
- IDLE transitions:
  - If dbg_req is high and uart_tx_active is low: latch dbg_data into uart_tx_data, pulse dbg_ack, go to START.
  - Else if the FIFO is non-empty and uart_tx_active is low: pop the head into uart_tx_data, go to START.
  - The debugger has fixed priority over the core FIFO.
  - If uart_tx_active is high in IDLE, stay in IDLE.
- START: uart_start_TX = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_ACT.
- WAIT_ACT:
  - uart_tx_active high -> WAIT_DONE.
  - Else increment the counter. At count START_TIMEOUT-1, set timeout_err and go to IDLE. The byte is abandoned, not retried.
- WAIT_DONE: uart_tx_active low -> IDLE.
- Minimum back-to-back spacing: one IDLE cycle between successive starts.
- Latency: a push in cycle N into an empty FIFO with idle UART gives the pop in cycle N+1 and uart_start_TX in cycle N+2.
- uart_tx_data and uart_start_TX are registered outputs. dbg_ack is registered and asserted in the cycle the FSM enters START.
- Error flags are sticky; only reset_n or sync_reset clears them.
- Reset mid-transfer: the FSM returns to IDLE immediately and the FIFO contents are discarded. The serializer may finish its current byte; the block ignores tx_active until it is back in IDLE.

Optional Feature:
UART_TX_DBG_EN
- Defined: debugger port arbitrated as described.
- Undefined: dbg_req is ignored, dbg_ack is tied 0, and only the core FIFO is served. The IDLE priority branch is removed from the FSM.

Test Plan:
- Reset, then push 8'h41 with a model serializer that raises tx_active 2 cycles after start and holds it 10 cycles:
  - uart_start_TX pulses once, 2 cycles after the push, with uart_tx_data = 8'h41.
  - busy falls 1 cycle after tx_active falls.
- Push 5 bytes 8'h01..8'h05 on consecutive cycles while the serializer is busy:
  - bytes 1..4 are buffered and core_fifo_full = 1;
  - byte 5 is dropped and overflow_err = 1;
  - transmit order is 01,02,03,04.
- With FIFO count = 4 and the FSM in IDLE, push in the same cycle as a pop: count stays 4 and no overflow_err is raised.
- With UART_TX_DBG_EN defined, dbg_req with 8'hA5 and the core FIFO holding 8'h10 in the same IDLE cycle:
  - dbg_ack pulses and 8'hA5 is sent first;
  - 8'h10 is sent next.
- Serializer never raises tx_active: timeout_err sets 16 cycles after the start pulse, the FSM returns to IDLE, and the next FIFO byte starts.
- Assert sync_reset during WAIT_DONE with 3 bytes queued: next cycle state is IDLE, count = 0, all flags 0, and no further uart_start_TX occurs.

Source files
------------

// File: rtl/reindeer_uart_tx_sched.sv
// Shares the UART TX serializer between a 2^FIFO_AW-entry core store FIFO and the debugger byte channel.
// Start pulse 2 cycles after a push into an empty FIFO; paced by tx_active. Optional debugger port: UART_TX_DBG_EN.
module reindeer_uart_tx_sched #(
  parameter int FIFO_AW       = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  input  logic               core_start_TX,
  input  logic [7:0]         core_tx_data,
  output logic               core_fifo_full,
  output logic [FIFO_AW:0]   core_fifo_count,
  input  logic               dbg_req,
  input  logic [7:0]         dbg_data,
  output logic               dbg_ack,
  output logic               uart_start_TX,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_active,
  output logic               busy,
  output logic               overflow_err,
  output logic               timeout_err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(START_TIMEOUT + 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [TW-1:0]      TMO_ONE  = TW'(1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACT, WAIT_DONE} state_t;

  state_t             state;
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [TW-1:0]      tmo_cnt;
  logic               fifo_empty;
  logic               dbg_take;
  logic               pop;
  logic               push;

  assign fifo_empty      = (count == '0);
  assign core_fifo_full  = (count == FULL_CNT);
  assign core_fifo_count = count;
  assign busy            = (state != IDLE) || !fifo_empty;

`ifdef UART_TX_DBG_EN
  assign dbg_take = (state == IDLE) && dbg_req && !uart_tx_active;
`else
  logic dbg_unused;
  assign dbg_unused = ^{dbg_req, dbg_data};
  assign dbg_take   = 1'b0;
  assign dbg_ack    = 1'b0;
`endif

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop  = (state == IDLE) && !uart_tx_active && !fifo_empty && !dbg_take;
  assign push = core_start_TX && (!core_fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (sync_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (core_start_TX && !push) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      uart_start_TX <= 1'b0;
      uart_tx_data  <= 8'h00;
      tmo_cnt       <= '0;
      timeout_err   <= 1'b0;
`ifdef UART_TX_DBG_EN
      dbg_ack       <= 1'b0;
`endif
    end else if (sync_reset) begin
      state         <= IDLE;
      uart_start_TX <= 1'b0;
      uart_tx_data  <= 8'h00;
      tmo_cnt       <= '0;
      timeout_err   <= 1'b0;
`ifdef UART_TX_DBG_EN
      dbg_ack       <= 1'b0;
`endif
    end else begin
      uart_start_TX <= 1'b0;
`ifdef UART_TX_DBG_EN
      dbg_ack       <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef UART_TX_DBG_EN
          if (dbg_take) begin
            uart_tx_data  <= dbg_data;
            uart_start_TX <= 1'b1;
            dbg_ack       <= 1'b1;
            state         <= START;
          end else
`endif
          if (pop) begin
            uart_tx_data  <= fifo_mem[rd_ptr];
            uart_start_TX <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_ACT;
        end
        WAIT_ACT: begin
          // A byte that never gets the serializer going is dropped, not retried.
          if (uart_tx_active) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt + TMO_ONE == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
